d_ff: RTL and testbench



---
 rtl/d_ff.sv | 76 +++++++
 tb/tb_d_ff.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/d_ff.sv
// -----------------------------------------------------------------------------
// d_ff -- edge-triggered D register with load enable and asynchronous,
// active-low reset. Basic storage cell for the controller datapath and the
// FSM state registers.
//
// Parameters
//   WIDTH    bit width of data and out (must be >= 1)
//   RST_VAL  value forced onto out while arst is low
//
// Ports
//   clk   in   1      system clock, rising edge active
//   arst  in   1      asynchronous reset, active low
//   en    in   1      load enable, sampled on the rising clk edge
//   data  in   WIDTH  value captured when en is high
//   out   out  WIDTH  registered output, driven straight from the flop
// -----------------------------------------------------------------------------
module d_ff #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out
);

    // Reject a zero or negative width while elaborating.
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "d_ff: WIDTH must be >= 1");
    end

    // Hold-mux in front of the flop: the clock is never gated by en.
    logic [WIDTH-1:0] d_next;

    always_comb begin
        // NOTE: default assignment first so the combinational block can never
        // infer a latch, even if more branches are added later.
        d_next = out;
        if (en) begin
            d_next = data;
        end
    end

    // Reset release is intentionally not synchronised here; the first capture
    // is the first rising edge that already sees arst high. An edge that
    // coincides with the release still sees arst low and keeps RST_VAL.
    always_ff @(posedge clk or negedge arst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!arst) begin
            out <= RST_VAL;
        end else begin
            out <= d_next;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only sanity checks; an unknown enable is a stimulus error,
    // not something the register is expected to propagate.
    always @(posedge clk) begin
        if (arst) begin
            assert (!$isunknown(en))
                else $error("d_ff: en is X/Z at a rising clk edge");
        end
    end

    always @(posedge clk) begin
        if (!arst) begin
            assert (out == RST_VAL)
                else $error("d_ff: out differs from RST_VAL while in reset");
        end
    end
`endif

endmodule

// File: tb/tb_d_ff.sv
// -----------------------------------------------------------------------------
// tb_d_ff -- self-checking bench for d_ff. Three instances share clk, arst and
// en: a 1-bit register resetting to 0, a 1-bit register resetting to 1, and an
// 8-bit register resetting to 8'h3C. A small reference model tracks the value
// each register should hold; a vector table and hand-written sequences cover
// the multi-cycle corner cases, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_d_ff;

    localparam logic [7:0] RST8 = 8'h3C;

    typedef struct packed {
        logic       en;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       arst;
    logic       en;
    logic [7:0] data;
    logic       q_a;
    logic       q_b;
    logic [7:0] q_w;

    // Reference model: what each register must hold right now.
    logic       m_a;
    logic       m_b;
    logic [7:0] m_w;

    int n_checks = 0;
    int n_fail   = 0;

    d_ff #(.WIDTH(1), .RST_VAL(1'b0)) u_a (
        .clk(clk), .arst(arst), .en(en), .data(data[0]), .out(q_a)
    );
    d_ff #(.WIDTH(1), .RST_VAL(1'b1)) u_b (
        .clk(clk), .arst(arst), .en(en), .data(data[0]), .out(q_b)
    );
    d_ff #(.WIDTH(8), .RST_VAL(RST8)) u_w (
        .clk(clk), .arst(arst), .en(en), .data(data), .out(q_w)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name);
        check({name, "/w1_r0"}, {7'b0, q_a}, {7'b0, m_a});
        check({name, "/w1_r1"}, {7'b0, q_b}, {7'b0, m_b});
        check({name, "/w8"},    q_w,         m_w);
    endtask

    task automatic model_reset();
        m_a = 1'b0;
        m_b = 1'b1;
        m_w = RST8;
    endtask

    // Register semantics at a rising edge: load when out of reset and enabled.
    task automatic model_edge();
        if (arst === 1'b1 && en === 1'b1) begin
            m_a = data[0];
            m_b = data[0];
            m_w = data;
        end
    endtask

    // Drive inputs between edges, take one rising edge, check just after it.
    task automatic step(input logic e, input logic [7:0] d, input string name);
        en   = e;
        data = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all(name);
    endtask

    vec_t vecs [10];

    initial begin
        vecs = '{
            '{1'b1, 8'hA5, 8'hA5},
            '{1'b0, 8'h5A, 8'hA5},
            '{1'b1, 8'h5A, 8'h5A},
            '{1'b1, 8'h00, 8'h00},
            '{1'b0, 8'hFF, 8'h00},
            '{1'b1, 8'hFF, 8'hFF},
            '{1'b0, 8'h00, 8'hFF},
            '{1'b1, 8'h3C, 8'h3C},
            '{1'b1, 8'hC3, 8'hC3},
            '{1'b0, 8'h81, 8'hC3}
        };

        // Power-up reset: held low for 100 ns, out pinned at RST_VAL.
        arst = 1'b1;
        en   = 1'b0;
        data = 8'h00;
        #2;
        arst = 1'b0;
        model_reset();
        #1;
        check_all("por_assert");
        repeat (5) begin
            @(negedge clk);
            check_all("por_hold");
        end

        // Release between edges; enable off keeps reset values.
        arst = 1'b1;
        repeat (5) step(1'b0, 8'hFF, "en_off");

        // Load then hold the same data.
        step(1'b1, 8'hFF, "load");
        repeat (4) step(1'b1, 8'hFF, "load_hold");

        // Asynchronous reset midway between edges, with en=1.
        @(negedge clk);
        arst = 1'b0;
        #1;
        model_reset();
        check_all("async_mid");
        #5;
        check_all("async_before_edge");
        step(1'b1, 8'hFF, "async_held");
        @(negedge clk);
        check_all("async_held_20ns");
        arst = 1'b1;
        step(1'b1, 8'hFF, "async_release");

        // Hold with en=0 while data changes, then re-enable.
        repeat (4) step(1'b0, 8'h00, "hold");
        step(1'b1, 8'h00, "reenable");

        // Table-driven vectors for the 8-bit register plus model on all three.
        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].d, "table");
            check("table_exp", q_w, vecs[i].exp);
        end

        // Data and enable wiggling between edges must not reach out.
        step(1'b1, 8'hA5, "w8_load_a5");
        check("w8_a5", q_w, 8'hA5);
        data = 8'h5A;
        #2;
        check("between_edges_1", q_w, 8'hA5);
        data = 8'hFF;
        en   = 1'b0;
        #2;
        check("between_edges_2", q_w, 8'hA5);
        data = 8'h00;
        en   = 1'b1;
        #2;
        check("between_edges_3", q_w, 8'hA5);
        step(1'b0, 8'h12, "between_hold");
        step(1'b1, 8'h5A, "between_load");

        // Reset released exactly on a rising edge: that edge is ignored. The
        // release is scheduled as an update so the flop samples it coincident
        // with, not before, the edge.
        @(negedge clk);
        en   = 1'b1;
        data = 8'hFF;
        arst = 1'b0;
        #1;
        model_reset();
        check_all("coincident_pre");
        @(posedge clk);
        arst <= 1'b1;
        #1;
        check_all("coincident_edge");
        step(1'b1, 8'h77, "coincident_next");

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) begin
                arst = 1'b0;
                #1;
                model_reset();
                check_all("rand_async");
                #3;
                arst = 1'b1;
            end
            step(1'($urandom_range(1)), 8'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
